// File: rtl/codec_pkg.sv
// Shared constants and helpers for the codec serial interface.
package codec_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int SAMPLE_DIV_DEF = 256;
    localparam int BCLK_DIV_DEF   = 4;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // Average of two signed samples, rounded toward minus infinity.
    function automatic logic [SAMPLE_W-1:0] mixSamples(input logic [SAMPLE_W-1:0] a,
                                                       input logic [SAMPLE_W-1:0] b);
        logic [SAMPLE_W:0] sum;
        sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        return sum[SAMPLE_W:1];
    endfunction

endpackage

// File: rtl/codec_frame_counter.sv
// Frame position counter: tracks cnt, half-frame offset, slot and BCLK phase,
// and registers the bclk/lrck decodes. The *Next_o outputs describe the cnt being entered.
module codec_frame_counter
    import codec_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int BCLK_DIV   = BCLK_DIV_DEF,
    parameter int CNT_W      = $clog2(SAMPLE_DIV),
    parameter int OFF_W      = $clog2(SAMPLE_DIV / 2),
    parameter int SLOT_W     = $clog2(SAMPLE_DIV / 2 / BCLK_DIV),
    parameter int PH_W       = $clog2(BCLK_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [CNT_W-1:0]  cntNext_o,
    output logic [OFF_W-1:0]  offNext_o,
    output logic [SLOT_W-1:0] slotNext_o,
    output logic [PH_W-1:0]   phaseNext_o,
    output channel_e          chanNext_o,
    output logic              bclk_o,
    output logic              lrck_o
);

    localparam int H = SAMPLE_DIV / 2;

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [OFF_W-1:0]  off_q,   off_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              half_q,  half_d;
    logic              bclk_q,  bclk_d;
    logic              frameWrap, halfWrap, phaseWrap;

    // Slot and phase advance incrementally so non-power-of-two dividers need no division.
    always_comb begin
        frameWrap = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        halfWrap  = (off_q == OFF_W'(H - 1));
        phaseWrap = (phase_q == PH_W'(BCLK_DIV - 1));
        cnt_d     = frameWrap ? '0 : cnt_q + 1'b1;
        off_d     = halfWrap ? '0 : off_q + 1'b1;
        phase_d   = phaseWrap ? '0 : phase_q + 1'b1;
        slot_d    = slot_q;
        if (halfWrap) begin
            slot_d = '0;
        end else if (phaseWrap) begin
            slot_d = slot_q + 1'b1;
        end
        half_d = half_q;
        if (frameWrap) begin
            half_d = 1'b0;
        end else if (halfWrap) begin
            half_d = 1'b1;
        end
        bclk_d = (phase_d >= PH_W'(BCLK_DIV / 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            off_q   <= '0;
            slot_q  <= '0;
            phase_q <= '0;
            half_q  <= 1'b0;
            bclk_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            bclk_q  <= bclk_d;
        end
    end

    assign cntNext_o   = cnt_d;
    assign offNext_o   = off_d;
    assign slotNext_o  = slot_d;
    assign phaseNext_o = phase_d;
    assign chanNext_o  = channel_e'(half_d);
    assign bclk_o      = bclk_q;
    assign lrck_o      = half_q;

endmodule

// File: rtl/codec_serdes.sv
// I2S serial interface to the audio codec: ADC capture, DAC serialization, DSP handshake.
// Define CODEC_MONO_MIX_EN to output the left/right average instead of the right word.
module codec_serdes
    import codec_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_dat,
    input  logic [SAMPLE_W-1:0] audio_input,
    output logic                bclk,
    output logic                lrck,
    output logic                dac_dat,
    output logic [SAMPLE_W-1:0] audio_output,
    output logic                sample_end,
    output logic                sample_req
);

    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int OFF_W  = $clog2(SAMPLE_DIV / 2);
    localparam int SLOT_W = $clog2(SAMPLE_DIV / 2 / BCLK_DIV);
    localparam int PH_W   = $clog2(BCLK_DIV);
    // Capture one clk after the BCLK rising edge; with BCLK_DIV = 2 that spills into the next slot.
    localparam int CAP_P  = (BCLK_DIV / 2 + 1) % BCLK_DIV;
    localparam int CAP_S0 = 1 + (BCLK_DIV / 2 + 1) / BCLK_DIV;
    localparam int CAP_SL = CAP_S0 + SAMPLE_W - 1;

    logic [CNT_W-1:0]    cntNext;
    logic [OFF_W-1:0]    offNext;
    logic [SLOT_W-1:0]   slotNext;
    logic [PH_W-1:0]     phaseNext;
    channel_e            chanNext;

    logic [SAMPLE_W-1:0] adcSh_q,     adcSh_d;
    logic                lastBit_q,   lastBit_d;
    channel_e            lastChan_q,  lastChan_d;
    logic                sampleEnd_q, sampleEnd_d;
    logic [SAMPLE_W-1:0] audioOut_q,  audioOut_d;
    logic                sampleReq_q, sampleReq_d;
    logic [SAMPLE_W-1:0] dac_q,       dac_d;
    logic [SAMPLE_W-1:0] dacSh_q,     dacSh_d;
    logic                dacDat_q,    dacDat_d;
    logic                capture, dacBitSlot;
    logic [SAMPLE_W-1:0] mixed;
`ifdef CODEC_MONO_MIX_EN
    logic [SAMPLE_W-1:0] left_q, left_d;
`endif

    codec_frame_counter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .BCLK_DIV   (BCLK_DIV),
        .CNT_W      (CNT_W),
        .OFF_W      (OFF_W),
        .SLOT_W     (SLOT_W),
        .PH_W       (PH_W)
    ) u_frame (
        .clk         (clk),
        .rst_n       (reset),
        .cntNext_o   (cntNext),
        .offNext_o   (offNext),
        .slotNext_o  (slotNext),
        .phaseNext_o (phaseNext),
        .chanNext_o  (chanNext),
        .bclk_o      (bclk),
        .lrck_o      (lrck)
    );

    // Every decision keys off the cnt being entered so registered outputs line up with cnt.
    always_comb begin
        capture     = (phaseNext == PH_W'(CAP_P)) &&
                      (slotNext >= SLOT_W'(CAP_S0)) && (slotNext <= SLOT_W'(CAP_SL));
        dacBitSlot  = (phaseNext == '0) &&
                      (slotNext >= SLOT_W'(1)) && (slotNext <= SLOT_W'(SAMPLE_W));
        adcSh_d     = capture ? {adcSh_q[SAMPLE_W-2:0], adc_dat} : adcSh_q;
        lastBit_d   = capture && (slotNext == SLOT_W'(CAP_SL));
        lastChan_d  = chanNext;
        sampleEnd_d = lastBit_q && (lastChan_q == CH_RIGHT);
`ifdef CODEC_MONO_MIX_EN
        left_d      = (lastBit_q && (lastChan_q == CH_LEFT)) ? adcSh_q : left_q;
        mixed       = mixSamples(left_q, adcSh_q);
`else
        mixed       = adcSh_q;
`endif
        audioOut_d  = sampleEnd_d ? mixed : audioOut_q;
        sampleReq_d = (cntNext == CNT_W'(SAMPLE_DIV - 2));
        dac_d       = (cntNext == CNT_W'(SAMPLE_DIV - 1)) ? audio_input : dac_q;
        dacSh_d     = dacSh_q;
        if (offNext == '0) begin
            dacSh_d = dac_q;
        end else if (dacBitSlot) begin
            dacSh_d = {dacSh_q[SAMPLE_W-2:0], 1'b0};
        end
        dacDat_d    = (phaseNext == '0) ? (dacBitSlot & dacSh_q[SAMPLE_W-1]) : dacDat_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adcSh_q     <= '0;
            lastBit_q   <= 1'b0;
            lastChan_q  <= CH_LEFT;
            sampleEnd_q <= 1'b0;
            audioOut_q  <= '0;
            sampleReq_q <= 1'b0;
            dac_q       <= '0;
            dacSh_q     <= '0;
            dacDat_q    <= 1'b0;
        end else begin
            adcSh_q     <= adcSh_d;
            lastBit_q   <= lastBit_d;
            lastChan_q  <= lastChan_d;
            sampleEnd_q <= sampleEnd_d;
            audioOut_q  <= audioOut_d;
            sampleReq_q <= sampleReq_d;
            dac_q       <= dac_d;
            dacSh_q     <= dacSh_d;
            dacDat_q    <= dacDat_d;
        end
    end

`ifdef CODEC_MONO_MIX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_q <= '0;
        end else begin
            left_q <= left_d;
        end
    end
`endif

    assign dac_dat      = dacDat_q;
    assign audio_output = audioOut_q;
    assign sample_end   = sampleEnd_q;
    assign sample_req   = sampleReq_q;

endmodule

// File: tb/tb_codec_serdes.sv
// Directed bench for codec_serdes: a codec model drives I2S ADC words per frame and
// every output is compared each cycle against hand-computed frame expectations.
module tb_codec_serdes;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_dat;
    logic [15:0] audio_input;
    logic        bclk, lrck, dac_dat, sample_end, sample_req;
    logic [15:0] audio_output;

    int checks = 0;
    int errors = 0;
    int tbCnt = 0;
    int frameIdx = -1;
    int seCnt = 0;
    int reqCnt = 0;
    logic [15:0] expAudio = 16'h0000;
    logic [15:0] curDac = 16'h0000;
    logic [15:0] latchWord = 16'h0000;

    // Per-frame codec words and the audio_output each frame must produce.
    logic [15:0] leftTab  [6] = '{16'h1234, 16'h8000, 16'h7FFF, 16'h5555, 16'h0F0F, 16'h0000};
    logic [15:0] rightTab [6] = '{16'hA5C3, 16'h8000, 16'h8000, 16'h1111, 16'h7FFF, 16'h0000};
`ifdef CODEC_MONO_MIX_EN
    logic [15:0] expTab   [6] = '{16'hDBFB, 16'h8000, 16'hFFFF, 16'h0000, 16'h4787, 16'h0000};
`else
    logic [15:0] expTab   [6] = '{16'hA5C3, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000};
`endif

    codec_serdes dut (
        .clk          (clk),
        .reset        (reset),
        .adc_dat      (adc_dat),
        .audio_input  (audio_input),
        .bclk         (bclk),
        .lrck         (lrck),
        .dac_dat      (dac_dat),
        .audio_output (audio_output),
        .sample_end   (sample_end),
        .sample_req   (sample_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s frame %0d cnt %0d: got 0x%0h, expected 0x%0h",
                     tag, frameIdx, tbCnt, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic [15:0] dataVal);
        reset       = rstVal;
        audio_input = dataVal;
    endtask

    task automatic waitFor(input int f, input int c);
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #2;
            if (frameIdx == f && tbCnt == c) return;
        end
        checkOutput("wait_timeout", 32'd0, 32'd1);
    endtask

    // Reference frame position, restarted by reset just like the codec would see it.
    always @(posedge clk or negedge reset) begin
        if (!reset) tbCnt <= 0;
        else        tbCnt <= (tbCnt == 255) ? 0 : tbCnt + 1;
    end

    // Frame model, per-cycle output checks and the codec's ADC driver.
    always @(negedge clk) begin
        int s;
        int fi;
        logic [15:0] word;
        if (!reset) begin
            expAudio  = 16'h0000;
            curDac    = 16'h0000;
            latchWord = 16'h0000;
            seCnt     = 0;
            reqCnt    = 0;
            checkOutput("rst_bclk", {31'd0, bclk}, 32'd0);
            checkOutput("rst_lrck", {31'd0, lrck}, 32'd0);
            checkOutput("rst_dac_dat", {31'd0, dac_dat}, 32'd0);
            checkOutput("rst_audio_output", {16'd0, audio_output}, 32'd0);
            checkOutput("rst_sample_end", {31'd0, sample_end}, 32'd0);
            checkOutput("rst_sample_req", {31'd0, sample_req}, 32'd0);
            adc_dat = 1'b0;
        end else begin
            if (tbCnt == 0) begin
                frameIdx++;
                curDac = latchWord;
            end
            fi = (frameIdx < 0) ? 0 : ((frameIdx > 5) ? 5 : frameIdx);
            if (tbCnt == 196) expAudio = expTab[fi];
            s = (tbCnt % 128) / 4;
            checkOutput("bclk", {31'd0, bclk}, {31'd0, ((tbCnt % 4) >= 2)});
            checkOutput("lrck", {31'd0, lrck}, {31'd0, (tbCnt >= 128)});
            checkOutput("sample_end", {31'd0, sample_end}, {31'd0, (tbCnt == 196)});
            checkOutput("sample_req", {31'd0, sample_req}, {31'd0, (tbCnt == 254)});
            checkOutput("audio_output", {16'd0, audio_output}, {16'd0, expAudio});
            checkOutput("dac_dat", {31'd0, dac_dat},
                        {31'd0, ((s >= 1 && s <= 16) ? curDac[16 - s] : 1'b0)});
            if (sample_end) seCnt++;
            if (sample_req) reqCnt++;
            if (tbCnt == 254) latchWord = audio_input;
            if (tbCnt == 255) begin
                checkOutput("sample_end_per_frame", seCnt, 32'd1);
                checkOutput("sample_req_per_frame", reqCnt, 32'd1);
                seCnt  = 0;
                reqCnt = 0;
            end
            word    = (tbCnt < 128) ? leftTab[fi] : rightTab[fi];
            adc_dat = (s >= 1 && s <= 16) ? word[16 - s] : 1'b0;
        end
    end

    initial begin
        int seenAt;
        adc_dat = 1'b0;
        applyStimulus(1'b1, 16'h8001);
        #1;
        applyStimulus(1'b0, 16'h8001);
        repeat (4) @(posedge clk);
        #2;
        applyStimulus(1'b1, 16'h8001);

        // Mid-word change: frame 1 keeps 0x8001, frame 2 carries the new word.
        waitFor(1, 10);
        applyStimulus(1'b1, 16'h3C5A);

        // Reset in the middle of frame 3 for three clocks.
        waitFor(3, 150);
        applyStimulus(1'b0, 16'h3C5A);
        repeat (3) @(posedge clk);
        #2;
        applyStimulus(1'b1, 16'h3C5A);

        seenAt = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sample_end) begin
                seenAt = i;
                break;
            end
        end
        checkOutput("first_sample_end_after_reset", seenAt, 32'd196);

        waitFor(5, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
